// File: rtl/dcsk_rx_pkg.sv
// Shared receiver-side definitions: FSM states, frame geometry and the
// correlation decision helper.
package dcsk_rx_pkg;

  localparam int FRAME_LEN = 256;
  localparam int SEED_W    = 16;
  localparam int IDX_W     = 8;
  localparam int AGREE_W   = 9;
  localparam int CORR_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Correlation = 2*agree - FRAME_LEN, computed one bit wider to keep the sign.
  function automatic logic signed [CORR_W:0] corr_from_agree(input logic [AGREE_W-1:0] agree);
    logic signed [CORR_W:0] doubled;
    doubled = $signed({1'b0, agree, 1'b0});
    return doubled - (CORR_W+1)'(FRAME_LEN);
  endfunction

  // Returns {bit, erasure}: values inside the dead zone [-thr, +thr] are erased.
  function automatic logic [1:0] decide(input logic signed [CORR_W:0] corr,
                                        input logic signed [CORR_W:0] thr);
    if (corr > thr) begin
      return 2'b10;
    end else if (corr < -thr) begin
      return 2'b00;
    end else begin
      return 2'b01;
    end
  endfunction

endpackage

// File: rtl/wire_shuffler_pkg.sv
// Wire permutation table shared by the chaos transmitter and receiver.
// Unshuffled sequence bit j is placed at position SHUFFLE_MATRIX[j].
package wire_shuffler_pkg;

  localparam int SHUF_LEN = 256;

  typedef logic [SHUF_LEN-1:0][7:0] shuffle_t;

  // An odd multiplier modulo 256 gives a bijection, so each position is hit once.
  function automatic shuffle_t build_shuffle();
    shuffle_t m;
    for (int j = 0; j < SHUF_LEN; j++) begin
      m[j] = 8'((j * 167 + 89) % 256);
    end
    return m;
  endfunction

  localparam shuffle_t SHUFFLE_MATRIX = build_shuffle();

endpackage

// File: rtl/chaos_xpander.sv
// Expands a 16-bit chaos seed into the 256-chip spreading sequence:
// U[16i+k] = x[i] ? x[k] : ~x[k], then scattered through the wire shuffle.
module chaos_xpander
  import wire_shuffler_pkg::*;
(
  input  logic [15:0]  chaos_i,
  output logic [255:0] seq_o
);

  logic [255:0] unshuf;

  // Outer-product style expansion: row i selects true or inverted seed.
  for (genvar gi = 0; gi < 16; gi++) begin : g_row
    for (genvar gk = 0; gk < 16; gk++) begin : g_col
      assign unshuf[16*gi+gk] = chaos_i[gi] ? chaos_i[gk] : ~chaos_i[gk];
    end
  end

  // Permutation: every output bit is driven by exactly one unshuffled bit.
  for (genvar gi = 0; gi < SHUF_LEN; gi++) begin : g_shuf
    assign seq_o[SHUFFLE_MATRIX[gi]] = unshuf[gi];
  end

endmodule

// File: rtl/chaos_despreader.sv
// Chaos-sequence despreader: correlates 256 received hard chips against the
// locally regenerated sequence and decides one data bit per frame, with an
// erasure dead zone of +/-THRESH around zero correlation.
module chaos_despreader
  import dcsk_rx_pkg::*;
#(
  parameter int unsigned THRESH = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_chaos,
  input  logic        i_chip,
  input  logic        i_chip_valid,
  output logic        o_chip_ready,
  output logic        o_frame_valid,
  output logic        o_bit,
  output logic        o_erasure,
  output logic [9:0]  o_corr,
  output logic [8:0]  o_agree_cnt
);

  localparam logic signed [CORR_W:0] THRESH_S = (CORR_W+1)'(THRESH);

  state_e                  state_q;
  logic [SEED_W-1:0]       chaos_q;
  logic [FRAME_LEN-1:0]    exp_q;
  logic [IDX_W-1:0]        idx_q;
  logic [AGREE_W-1:0]      agree_q;
  logic                    frame_valid_q;
  logic                    bit_q;
  logic                    erasure_q;
  logic [CORR_W-1:0]       corr_q;
  logic [AGREE_W-1:0]      agree_out_q;

  logic [FRAME_LEN-1:0]    exp_seq;
  logic                    chip_acc;
  logic                    chip_match;
  logic                    last_chip;
  logic [AGREE_W-1:0]      agree_d;
  logic signed [CORR_W:0]  corr_d;
  logic [1:0]              decision_d;

  // Sequence generator runs on the latched seed; its output is captured in LOAD.
  chaos_xpander u_xpander (
    .chaos_i (chaos_q),
    .seq_o   (exp_seq)
  );

  // A start request in ACCUM pre-empts any chip offered in the same cycle.
  assign o_chip_ready = (state_q == ST_ACCUM) & ~i_start;
  assign chip_acc     = i_chip_valid & o_chip_ready;
  assign chip_match   = (i_chip == exp_q[idx_q]);
  assign last_chip    = (idx_q == IDX_W'(FRAME_LEN - 1));

  // Running agreement including the chip accepted this cycle, and its decision.
  always_comb begin
    agree_d    = agree_q + {{(AGREE_W-1){1'b0}}, chip_match};
    corr_d     = corr_from_agree(agree_d);
    decision_d = decide(corr_d, THRESH_S);
  end

  // Frame control FSM with registered result outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      chaos_q       <= '0;
      exp_q         <= '0;
      idx_q         <= '0;
      agree_q       <= '0;
      frame_valid_q <= 1'b0;
      bit_q         <= 1'b0;
      erasure_q     <= 1'b0;
      corr_q        <= '0;
      agree_out_q   <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            chaos_q <= i_chaos;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Start requests here are deliberately ignored.
          exp_q   <= exp_seq;
          idx_q   <= '0;
          agree_q <= '0;
          state_q <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (i_start) begin
            // Abort: drop partial frame and reload with the new seed.
            chaos_q <= i_chaos;
            state_q <= ST_LOAD;
          end else if (chip_acc) begin
            idx_q   <= idx_q + IDX_W'(1);
            agree_q <= agree_d;
            if (last_chip) begin
              state_q       <= ST_DONE;
              frame_valid_q <= 1'b1;
              bit_q         <= decision_d[1];
              erasure_q     <= decision_d[0];
              corr_q        <= corr_d[CORR_W-1:0];
              agree_out_q   <= agree_d;
            end
          end
        end
        ST_DONE: begin
          if (i_start) begin
            chaos_q <= i_chaos;
            state_q <= ST_LOAD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_frame_valid = frame_valid_q;
  assign o_bit         = bit_q;
  assign o_erasure     = erasure_q;
  assign o_corr        = corr_q;
  assign o_agree_cnt   = agree_out_q;

endmodule

// File: tb/tb_chaos_despreader.sv
// Directed bench for chaos_despreader with a result scoreboard.
module tb_chaos_despreader;
  import wire_shuffler_pkg::*;

  localparam int TH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] chaos = 16'h0;
  logic        chip = 1'b0;
  logic        chip_valid = 1'b0;
  logic        chip_ready;
  logic        frame_valid;
  logic        bit_o;
  logic        erasure;
  logic [9:0]  corr;
  logic [8:0]  agree_cnt;

  chaos_despreader #(.THRESH(TH)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_chaos       (chaos),
    .i_chip        (chip),
    .i_chip_valid  (chip_valid),
    .o_chip_ready  (chip_ready),
    .o_frame_valid (frame_valid),
    .o_bit         (bit_o),
    .o_erasure     (erasure),
    .o_corr        (corr),
    .o_agree_cnt   (agree_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       b;
    logic       e;
    logic [9:0] c;
    logic [8:0] a;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   fv_count = 0;
  int   last_fv_cyc = 0;
  int   start_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [255:0] model_e(input logic [15:0] x);
    logic [255:0] u;
    logic [255:0] e;
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 16; k++)
        u[16*i+k] = x[i] ? x[k] : ~x[k];
    e = '0;
    for (int j = 0; j < 256; j++) e[SHUFFLE_MATRIX[j]] = u[j];
    return e;
  endfunction

  function automatic exp_t expect_from(input int agree);
    exp_t r;
    int   c;
    c    = 2 * agree - 256;
    r.a  = 9'(agree);
    r.c  = 10'(c);
    r.b  = (c > TH);
    r.e  = (c <= TH) && (c >= -TH);
    return r;
  endfunction

  // Monitor: every frame_valid pulse must match the oldest expected result.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (frame_valid) begin
        fv_count++;
        last_fv_cyc = cyc;
        if (sb.size() == 0) begin
          chk("spurious_frame_valid", 32'd1, 32'd0);
        end else begin
          x = sb.pop_front();
          $display("frame %0d: bit=%0b era=%0b corr=%0d agree=%0d", fv_count, bit_o, erasure,
                   $signed(corr), agree_cnt);
          chk("frame_bit", {31'd0, bit_o}, {31'd0, x.b});
          chk("frame_erasure", {31'd0, erasure}, {31'd0, x.e});
          chk("frame_corr", {22'd0, corr}, {22'd0, x.c});
          chk("frame_agree", {23'd0, agree_cnt}, {23'd0, x.a});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [15:0] seed);
    chaos = seed;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic send_chips(input logic [255:0] pat, input int count, input int duty);
    int   n;
    int   guard;
    logic acc;
    n = 0;
    guard = 0;
    while (n < count && guard < 5000) begin
      chip_valid = ($urandom_range(99) < duty);
      chip = pat[n];
      #1;
      acc = chip_valid && chip_ready;
      tick();
      if (acc) n++;
      guard++;
    end
    chip_valid = 1'b0;
    if (n < count) chk("chip_timeout", n, count);
  endtask

  task automatic wait_fv(input string tag);
    int i;
    i = 0;
    while (!frame_valid && i < 600) begin
      tick();
      i++;
    end
    if (!frame_valid) chk(tag, 32'd0, 32'd1);
    tick();
    chk({tag, "_one_cycle"}, {31'd0, frame_valid}, 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, chip_ready}, 32'd0);
    chk({tag, "_fv"}, {31'd0, frame_valid}, 32'd0);
    chk({tag, "_bit"}, {31'd0, bit_o}, 32'd0);
    chk({tag, "_erasure"}, {31'd0, erasure}, 32'd0);
    chk({tag, "_corr"}, {22'd0, corr}, 32'd0);
    chk({tag, "_agree"}, {23'd0, agree_cnt}, 32'd0);
  endtask

  initial begin
    logic [255:0] ea;
    logic [255:0] eb;
    logic [255:0] p;
    int           fv_before;
    int           readies;

    ea = model_e(16'hA5C3);
    eb = model_e(16'h1234);

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_ready", {31'd0, chip_ready}, 32'd0);

    // Matching chips back-to-back, with latency check
    sb.push_back(expect_from(256));
    start_frame(16'hA5C3);
    send_chips(ea, 256, 100);
    wait_fv("t1_fv");
    chk("t1_latency", last_fv_cyc - start_cyc, 32'd258);
    repeat (5) tick();
    chk("t1_hold_corr", {22'd0, corr}, 32'd256);

    // Inverted chips
    sb.push_back(expect_from(0));
    start_frame(16'hA5C3);
    send_chips(~ea, 256, 100);
    wait_fv("t2_fv");

    // 120 matches: inside dead zone
    p = ea;
    for (int n = 120; n < 256; n++) p[n] = ~ea[n];
    sb.push_back(expect_from(120));
    start_frame(16'hA5C3);
    send_chips(p, 256, 100);
    wait_fv("t3a_fv");

    // 137 matches: just outside dead zone
    p = ea;
    for (int n = 137; n < 256; n++) p[n] = ~ea[n];
    sb.push_back(expect_from(137));
    start_frame(16'hA5C3);
    send_chips(p, 256, 100);
    wait_fv("t3b_fv");

    // Sparse valid, 30% duty
    fv_before = fv_count;
    sb.push_back(expect_from(256));
    start_frame(16'hA5C3);
    send_chips(ea, 256, 30);
    wait_fv("t4_fv");
    chk("t4_fv_once", fv_count - fv_before, 32'd1);

    // Abort after 100 chips, restart with new seed
    fv_before = fv_count;
    start_frame(16'hA5C3);
    send_chips(ea, 100, 100);
    chaos = 16'h1234;
    start = 1'b1;
    chip_valid = 1'b1;
    chip = ~eb[0];
    #1;
    chk("t5_ready_during_start", {31'd0, chip_ready}, 32'd0);
    tick();
    start = 1'b0;
    chip_valid = 1'b0;
    sb.push_back(expect_from(256));
    send_chips(eb, 256, 100);
    wait_fv("t5_fv");
    chk("t5_fv_once", fv_count - fv_before, 32'd1);

    // Asynchronous reset mid-frame
    fv_before = fv_count;
    start_frame(16'hA5C3);
    send_chips(ea, 200, 100);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t6_rst");
    tick();
    rst_n = 1'b1;
    readies = 0;
    for (int i = 0; i < 20; i++) begin
      chip_valid = 1'b1;
      chip = ea[i];
      #1;
      if (chip_ready) readies++;
      tick();
    end
    chip_valid = 1'b0;
    chk("t6_ready_after_reset", readies, 32'd0);
    chk("t6_no_fv", fv_count - fv_before, 32'd0);

    // Recovery frame after reset
    sb.push_back(expect_from(256));
    start_frame(16'h1234);
    send_chips(eb, 256, 100);
    wait_fv("t7_fv");

    repeat (3) tick();
    chk("sb_empty", sb.size(), 32'd0);
    chk("fv_total", fv_count, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
